// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts a signed Cartesian point (x, y) into
// a gain-scaled magnitude and a binary angle atan2(y, x), one micro-rotation per clock.
module cordic_vectoring #(
    parameter int POINT_WIDTH = 16,
    parameter int ITERATIONS  = 16,
    parameter int ANGLE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic signed [POINT_WIDTH-1:0] x_in,
    input  logic signed [POINT_WIDTH-1:0] y_in,
    output logic        [POINT_WIDTH:0]   mag_out,
    output logic        [ANGLE_WIDTH-1:0] angle_out,
    output logic                          done,
    output logic                          busy
);

    localparam int XW = POINT_WIDTH + 2;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CW-1:0]          LAST_ITER = CW'(ITERATIONS - 1);
    localparam logic [ANGLE_WIDTH-1:0] QUARTER   = ANGLE_WIDTH'(1) << (ANGLE_WIDTH - 2);
    localparam real                    PI        = 3.14159265358979323846;

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

    // Arctangent table, one entry per micro-rotation, fixed at elaboration.
    logic [ANGLE_WIDTH-1:0] atan_rom [ITERATIONS];

    genvar gi;
    generate
        for (gi = 0; gi < ITERATIONS; gi++) begin : g_atan
            localparam real ANG_R = $atan(1.0 / (2.0 ** gi)) * (2.0 ** ANGLE_WIDTH) / (2.0 * PI);
            assign atan_rom[gi] = ANGLE_WIDTH'($rtoi(ANG_R + 0.5));
        end
    endgenerate

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d;
    logic signed [XW-1:0]    y_q, y_d;
    logic [ANGLE_WIDTH-1:0]  z_q, z_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    zero_q, zero_d;
    logic [POINT_WIDTH:0]    mag_q, mag_d;
    logic [ANGLE_WIDTH-1:0]  angle_q, angle_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic signed [XW-1:0]    x_ext, y_ext, x_sh, y_sh;

    assign x_ext = {{2{x_in[POINT_WIDTH-1]}}, x_in};
    assign y_ext = {{2{y_in[POINT_WIDTH-1]}}, y_in};
    assign x_sh  = x_q >>> cnt_q;
    assign y_sh  = y_q >>> cnt_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        mag_d   = mag_q;
        angle_d = angle_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Pre-rotate by +/-90 deg so the iterations only see x >= 0.
                    if (!x_ext[XW-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!y_ext[XW-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = QUARTER;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = -QUARTER;
                    end
                    zero_d  = (x_in == '0) && (y_in == '0);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_rom[cnt_q];
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_rom[cnt_q];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    // The origin has no defined angle; report 0 instead of the summed table.
                    mag_d   = x_d[POINT_WIDTH:0];
                    angle_d = zero_q ? '0 : z_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            mag_q   <= '0;
            angle_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            mag_q   <= mag_d;
            angle_q <= angle_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign mag_out   = mag_q;
    assign angle_out = angle_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: handshake timing, quadrant coverage,
// extreme inputs, busy-time start handling and asynchronous abort.
module tb_cordic_vectoring;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic        [16:0] mag_out;
    logic        [15:0] angle_out;
    logic               done;
    logic               busy;

    int checks = 0;
    int failures = 0;

    cordic_vectoring #(
        .POINT_WIDTH(16),
        .ITERATIONS (16),
        .ANGLE_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .mag_out  (mag_out),
        .angle_out(angle_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int angle_err(input logic [15:0] a, input logic [15:0] e);
        logic signed [15:0] d;
        d = a - e;
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    function automatic int mag_err(input logic [16:0] m, input int e);
        int d;
        d = int'(m) - e;
        return (d < 0) ? -d : d;
    endfunction

    // Leaves the caller at the falling edge just after the accepting edge.
    task automatic launch(input logic signed [15:0] xv, input logic signed [15:0] yv);
        @(negedge clk);
        x_in  = xv;
        y_in  = yv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts clock edges until done is seen, bounded so a dead DUT cannot hang the run.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
        checks++; if (mag_out !== 17'd0) begin failures++; $display("FAIL reset_mag got=%0d want=0", mag_out); end
        checks++; if (angle_out !== 16'd0) begin failures++; $display("FAIL reset_angle got=%h want=0000", angle_out); end
        rst = 1'b0;
        $display("reset: busy=%0b done=%0b mag=%0d angle=%h", busy, done, mag_out, angle_out);
    endtask

    task automatic test_axis_x(input string tag);
        int cyc, bc;
        launch(16'sd10000, 16'sd0);
        wait_done(cyc, bc);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL %s_latency got=%0d want=16", tag, cyc); end
        checks++; if (bc !== 16) begin failures++; $display("FAIL %s_busy_cycles got=%0d want=16", tag, bc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%0b want=0", tag, busy); end
        checks++; if (mag_err(mag_out, 16468) > 6) begin failures++; $display("FAIL %s_mag got=%0d want=16468+/-6", tag, mag_out); end
        checks++; if (angle_err(angle_out, 16'h0000) > 2) begin failures++; $display("FAIL %s_angle got=%h want=0000+/-2", tag, angle_out); end
        $display("%s: x=10000 y=0 latency=%0d mag=%0d angle=%h", tag, cyc, mag_out, angle_out);
    endtask

    task automatic test_first_quadrant();
        int cyc, bc;
        launch(16'sd10000, 16'sd10000);
        wait_done(cyc, bc);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL q1_latency got=%0d want=16", cyc); end
        checks++; if (angle_err(angle_out, 16'h2000) > 2) begin failures++; $display("FAIL q1_angle got=%h want=2000+/-2", angle_out); end
        checks++; if (mag_err(mag_out, 23289) > 6) begin failures++; $display("FAIL q1_mag got=%0d want=23289+/-6", mag_out); end
        $display("q1: x=10000 y=10000 mag=%0d angle=%h", mag_out, angle_out);
    endtask

    task automatic test_neg_x();
        int cyc, bc;
        launch(-16'sd10000, 16'sd0);
        wait_done(cyc, bc);
        checks++; if (angle_err(angle_out, 16'h8000) > 2) begin failures++; $display("FAIL negx_angle got=%h want=8000+/-2", angle_out); end
        checks++; if (mag_err(mag_out, 16468) > 6) begin failures++; $display("FAIL negx_mag got=%0d want=16468+/-6", mag_out); end
        $display("negx: x=-10000 y=0 mag=%0d angle=%h", mag_out, angle_out);
    endtask

    task automatic test_neg_y();
        int cyc, bc;
        launch(16'sd0, -16'sd20000);
        wait_done(cyc, bc);
        checks++; if (angle_err(angle_out, 16'hC000) > 2) begin failures++; $display("FAIL negy_angle got=%h want=C000+/-2", angle_out); end
        checks++; if (mag_err(mag_out, 32935) > 6) begin failures++; $display("FAIL negy_mag got=%0d want=32935+/-6", mag_out); end
        $display("negy: x=0 y=-20000 mag=%0d angle=%h", mag_out, angle_out);
    endtask

    task automatic test_corner();
        int cyc, bc;
        launch(-16'sd32768, -16'sd32768);
        wait_done(cyc, bc);
        checks++; if (angle_err(angle_out, 16'hA000) > 2) begin failures++; $display("FAIL corner_angle got=%h want=A000+/-2", angle_out); end
        checks++; if (mag_err(mag_out, 76313) > 6) begin failures++; $display("FAIL corner_mag got=%0d want=76313+/-6", mag_out); end
        $display("corner: x=-32768 y=-32768 mag=%0d angle=%h", mag_out, angle_out);
    endtask

    task automatic test_zero();
        int cyc, bc;
        launch(16'sd0, 16'sd0);
        wait_done(cyc, bc);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL zero_latency got=%0d want=16", cyc); end
        checks++; if (mag_out !== 17'd0) begin failures++; $display("FAIL zero_mag got=%0d want=0", mag_out); end
        checks++; if (angle_out !== 16'h0000) begin failures++; $display("FAIL zero_angle got=%h want=0000", angle_out); end
        $display("zero: x=0 y=0 mag=%0d angle=%h", mag_out, angle_out);
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        launch(16'sd10000, 16'sd10000);
        repeat (4) @(negedge clk);
        x_in  = -16'sd10000;
        y_in  = 16'sd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        checks++; if (cyc + 5 !== 16) begin failures++; $display("FAIL ignore_latency got=%0d want=16", cyc + 5); end
        checks++; if (angle_err(angle_out, 16'h2000) > 2) begin failures++; $display("FAIL ignore_angle got=%h want=2000+/-2", angle_out); end
        checks++; if (mag_err(mag_out, 23289) > 6) begin failures++; $display("FAIL ignore_mag got=%0d want=23289+/-6", mag_out); end
        $display("ignore: busy-time start dropped, mag=%0d angle=%h", mag_out, angle_out);
        // Start raised during the done cycle must be accepted.
        x_in  = 16'sd0;
        y_in  = -16'sd20000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_pulse got=%0b want=0", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%0b want=1", busy); end
        wait_done(cyc, bc);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL b2b_latency got=%0d want=16", cyc); end
        checks++; if (angle_err(angle_out, 16'hC000) > 2) begin failures++; $display("FAIL b2b_angle got=%h want=C000+/-2", angle_out); end
        checks++; if (mag_err(mag_out, 32935) > 6) begin failures++; $display("FAIL b2b_mag got=%0d want=32935+/-6", mag_out); end
        $display("b2b: x=0 y=-20000 latency=%0d mag=%0d angle=%h", cyc, mag_out, angle_out);
    endtask

    task automatic test_reset_mid();
        int pulses;
        launch(-16'sd10000, 16'sd0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%0b want=0", done); end
        checks++; if (mag_out !== 17'd0) begin failures++; $display("FAIL abort_mag got=%0d want=0", mag_out); end
        checks++; if (angle_out !== 16'd0) begin failures++; $display("FAIL abort_angle got=%h want=0000", angle_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
        $display("abort: mid-conversion reset, done pulses afterwards=%0d", pulses);
    endtask

    initial begin
        test_reset();
        test_axis_x("axis");
        test_first_quadrant();
        test_neg_x();
        test_neg_y();
        test_corner();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_axis_x("post_abort");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
Iterative CORDIC in vectoring mode, the inverse of the existing rotation-mode cordic block. It takes a signed Cartesian point (x, y) and returns the gain-scaled magnitude and the angle atan2(y, x) as a binary angle. It uses a start/done handshake with a busy flag and the same width parameters as the rotation core. The two blocks pair for polar/rectangular conversion.

Parameters:
POINT_WIDTH, 16, width of signed two's-complement x_in/y_in
ITERATIONS, 16, micro-rotations per conversion; legal range 1..ANGLE_WIDTH
ANGLE_WIDTH, 16, width of angle_out; binary angle, full circle = 2^ANGLE_WIDTH (0x4000 = +90 deg at 16 bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only when idle
x_in  in  POINT_WIDTH  signed x; sampled on the accepting edge
y_in  in  POINT_WIDTH  signed y; sampled on the accepting edge
mag_out  out  POINT_WIDTH+1  unsigned magnitude, K*sqrt(x^2+y^2), K = 1.646760 at 16 iterations
angle_out  out  ANGLE_WIDTH  signed binary angle atan2(y, x), wraps mod 2^ANGLE_WIDTH
done  out  1  one-cycle pulse; results are valid
busy  out  1  high while a conversion is in progress

Behaviour:
- Reset (async assert, sync release): state IDLE; mag_out, angle_out, done, busy, iteration counter and internal x/y/z all 0.
- Internal x and y are signed POINT_WIDTH+2 bits; z is ANGLE_WIDTH bits. Sign-extend inputs; no overflow is possible (max 2.33 * 2^(POINT_WIDTH-1)).
- Atan ROM: entry i = round(atan(2^-i) * 2^ANGLE_WIDTH / (2*pi)), i = 0..ITERATIONS-1, computed at elaboration.
- FSM IDLE -> ITER -> IDLE.
- IDLE, start=1 at edge E0: capture the inputs with quadrant pre-rotation:
  - x >= 0: (x, y), z = 0.
  - x < 0, y >= 0: (y, -x), z = +2^(ANGLE_WIDTH-2).
  - x < 0, y < 0: (-y, x), z = -2^(ANGLE_WIDTH-2).
  - Then busy=1, counter=0, go to ITER.
- ITER, one micro-rotation per edge, with shifts arithmetic:
  - y >= 0: x += y>>>i, y -= x>>>i, z += atan[i].
  - y < 0: x -= y>>>i, y += x>>>i, z -= atan[i].
  - Both updates use the pre-edge x and y. z add/sub wraps modulo 2^ANGLE_WIDTH.
- Completion: on edge E_ITERATIONS (the last micro-rotation), register mag_out = x_final[POINT_WIDTH:0] and angle_out = z_final. On that same edge set done=1, busy=0 and return to IDLE.
- done clears on the next edge. mag_out and angle_out hold until the next completion.
- Latency: done is high exactly ITERATIONS cycles after the accepting edge. Throughput is one conversion per ITERATIONS+1 cycles; a start held high continuously restarts on the edge after done.
- start while busy: ignored; no queuing; x_in/y_in changes have no effect.
- start in the done cycle: accepted (FSM is already IDLE).
- x=0, y=0: mag_out=0, angle_out=0.
- x<0, y=0: angle_out near 2^(ANGLE_WIDTH-1) (+/-180 deg); either wrap neighbour is legal within tolerance.
- Reset mid-conversion: immediate abort; every output returns to its reset value; no done pulse.
- Accuracy at defaults: |angle error| <= 2 LSB, |mag error| <= 6 LSB versus K*sqrt(x^2+y^2).

Test Plan:
- Reset/handshake: rst=1 mid-ITER -> busy=0, done=0, mag_out=0, angle_out=0 asynchronously; then start with x=10000, y=0 -> done exactly 16 cycles after the accepting edge, busy high for those 16 cycles, mag_out 16468+/-6, angle_out 0+/-2.
- First quadrant: x=10000, y=10000 -> angle_out 0x2000+/-2, mag_out 23289+/-6.
- Negative x-axis: x=-10000, y=0 -> angle_out within 2 LSB of 0x8000 (mod 2^16), mag_out 16468+/-6.
- Negative y-axis: x=0, y=-20000 -> angle_out 0xC000+/-2, mag_out 32935+/-6.
- Extreme corner: x=-32768, y=-32768 -> angle_out 0xA000+/-2, mag_out 76313+/-6, no overflow.
- start while busy: pulse start with new inputs at cycle 5 of a conversion -> ignored, first result unchanged. Start in the done cycle -> accepted, next done 16 cycles later.
